// File: rtl/led_countdown_pkg.sv
// Shared types and helpers for the LED-bar countdown timer.
// Optional feature macro used by the top: LED_COUNTDOWN_BLINK_EN.
package led_countdown_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } cd_state_t;

    // Bits needed to hold any value 0..n inclusive.
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running prescaler: emits a one-cycle tick every TICK_CYCLES enabled
// cycles. clr forces the count back to 0 and takes priority over en.
// Reusable by any block that needs a slow timebase.
module tick_prescaler #(
    parameter int TICK_CYCLES = 50_000_000
) (
    input  logic CLOCK,
    input  logic RESETN,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int             CW   = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CW-1:0]  LAST = CW'(TICK_CYCLES - 1);

    logic [CW-1:0] r_count;

    // tick is combinational so the consumer can act on the same edge the count wraps
    assign tick = en && (r_count == LAST);

    // Count 0..TICK_CYCLES-1 while enabled, hold while disabled, wrap after the last value
    always_ff @(posedge CLOCK or negedge RESETN) begin
        if (!RESETN) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (en) begin
            // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
            r_count <= (r_count == LAST) ? '0 : r_count + CW'(1);
        end
    end

endmodule

// File: rtl/led_countdown_bar.sv
// LED-bar countdown timer: lights all N_LEDS on start, then turns one off per
// prescaler tick from the MSB down, raising loa and a done pulse when empty.
// Optional feature macro: LED_COUNTDOWN_BLINK_EN (blink the bar while in DONE).
module led_countdown_bar
    import led_countdown_pkg::*;
#(
    parameter int N_LEDS      = 11,
    parameter int TICK_CYCLES = 50_000_000
) (
    input  logic                            CLOCK,
    input  logic                            RESETN,
    input  logic                            start,
    input  logic                            pause,
    input  logic                            abort,
    output logic [N_LEDS-1:0]               led,
    output logic [cnt_w(N_LEDS)-1:0]        remaining,
    output logic                            loa,
    output logic                            done
);

    localparam int                RW      = cnt_w(N_LEDS);
    localparam logic [N_LEDS-1:0] LED_ALL = '1;

    cd_state_t           r_state;
    logic [N_LEDS-1:0]   r_led;
    logic [RW-1:0]       r_remaining;
    logic                r_loa;
    logic                r_done;

    logic                w_accept;
    logic                w_pres_en;
    logic                w_pres_clr;
    logic                w_tick;

    // start is honoured only outside RUN and is dropped when abort is present
    assign w_accept   = start && !abort && (r_state != RUN);
    assign w_pres_clr = abort || w_accept;

`ifdef LED_COUNTDOWN_BLINK_EN
    // Prescaler keeps running in DONE to pace the blink
    assign w_pres_en  = ((r_state == RUN) || (r_state == DONE)) && !pause;
`else
    // Prescaler only runs while counting down; in DONE it idles at 0
    assign w_pres_en  = (r_state == RUN) && !pause;
`endif

    tick_prescaler #(
        .TICK_CYCLES (TICK_CYCLES)
    ) u_prescaler (
        .CLOCK  (CLOCK),
        .RESETN (RESETN),
        .en     (w_pres_en),
        .clr    (w_pres_clr),
        .tick   (w_tick)
    );

    // FSM with registered outputs; priority is abort > start > tick
    always_ff @(posedge CLOCK or negedge RESETN) begin
        if (!RESETN) begin
            // NOTE: every flop here is reset asynchronously; the bar must go dark the moment RESETN drops.
            r_state     <= IDLE;
            r_led       <= '0;
            r_remaining <= '0;
            r_loa       <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            // NOTE: default-low here and set below makes done a single-cycle pulse.
            r_done <= 1'b0;
            if (abort) begin
                r_state     <= IDLE;
                r_led       <= '0;
                r_remaining <= '0;
                r_loa       <= 1'b0;
            end else if (w_accept) begin
                r_state     <= RUN;
                r_led       <= LED_ALL;
                r_remaining <= RW'(N_LEDS);
                r_loa       <= 1'b0;
            end else if (w_tick) begin
                if (r_state == RUN) begin
                    // Shifting right clears led[remaining-1] and keeps led == (1<<remaining)-1
                    r_led       <= r_led >> 1;
                    r_remaining <= r_remaining - RW'(1);
                    if (r_remaining == RW'(1)) begin
                        r_state <= DONE;
                        r_loa   <= 1'b1;
                        r_done  <= 1'b1;
                    end
                end
`ifdef LED_COUNTDOWN_BLINK_EN
                else if (r_state == DONE) begin
                    r_led <= ~r_led;
                end
`endif
            end
        end
    end

    assign led       = r_led;
    assign remaining = r_remaining;
    assign loa       = r_loa;
    assign done      = r_done;

endmodule

// File: tb/tb_led_countdown_bar.sv
// Self-checking bench for led_countdown_bar (N_LEDS=4, TICK_CYCLES=3).
// Honours LED_COUNTDOWN_BLINK_EN when the build defines it.
module tb_led_countdown_bar;

    localparam int N = 4;
    localparam int T = 3;

    logic         clock  = 1'b0;
    logic         resetn = 1'b1;
    logic         start  = 1'b0;
    logic         pause  = 1'b0;
    logic         abort  = 1'b0;
    logic [N-1:0] led;
    logic [2:0]   remaining;
    logic         loa;
    logic         done;

    int n_cmp = 0;
    int n_bad = 0;

    led_countdown_bar #(
        .N_LEDS      (N),
        .TICK_CYCLES (T)
    ) dut (
        .CLOCK     (clock),
        .RESETN    (resetn),
        .start     (start),
        .pause     (pause),
        .abort     (abort),
        .led       (led),
        .remaining (remaining),
        .loa       (loa),
        .done      (done)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- Reference model ----------------
    // Tracks only the mode and how many unpaused cycles have elapsed since
    // entering RUN / DONE; outputs are derived from those with arithmetic.
    typedef enum {M_IDLE, M_RUN, M_DONE} mmode_t;
    mmode_t m_mode   = M_IDLE;
    int     m_run_t  = 0;
    int     m_done_t = 0;
    bit     m_loa    = 0;
    bit     m_done   = 0;

    function automatic void model_reset();
        m_mode = M_IDLE; m_run_t = 0; m_done_t = 0; m_loa = 0; m_done = 0;
    endfunction

    function automatic void model_step(input bit s, input bit p, input bit a);
        m_done = 0;
        if (a) begin
            m_mode = M_IDLE;
            m_loa  = 0;
        end else if (s && m_mode != M_RUN) begin
            m_mode  = M_RUN;
            m_run_t = 0;
            m_loa   = 0;
        end else if (!p) begin
            if (m_mode == M_RUN) begin
                m_run_t++;
                if (m_run_t == N * T) begin
                    m_mode   = M_DONE;
                    m_loa    = 1;
                    m_done   = 1;
                    m_done_t = 0;
                end
            end else if (m_mode == M_DONE) begin
                m_done_t++;
            end
        end
    endfunction

    function automatic int m_rem();
        return (m_mode == M_RUN) ? N - m_run_t / T : 0;
    endfunction

    function automatic logic [N-1:0] m_led();
        if (m_mode == M_DONE) begin
`ifdef LED_COUNTDOWN_BLINK_EN
            return ((m_done_t / T) % 2 == 1) ? {N{1'b1}} : {N{1'b0}};
`else
            return '0;
`endif
        end
        return N'((1 << m_rem()) - 1);
    endfunction

    // One clock: drive inputs, let the edge happen, advance model, compare.
    task automatic cycle(input bit s, input bit p, input bit a);
        start = s; pause = p; abort = a;
        @(posedge clock);
        model_step(s, p, a);
        #1;
        check("led",       led,       m_led());
        check("remaining", remaining, m_rem());
        check("loa",       loa,       m_loa);
        check("done",      done,      m_done);
        start = 0; pause = 0; abort = 0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_led"},  led,       0);
        check({tag, "_rem"},  remaining, 0);
        check({tag, "_loa"},  loa,       0);
        check({tag, "_done"}, done,      0);
    endtask

    // ---------------- Directed table ----------------
    typedef struct {
        bit         s, p, a;
        logic [3:0] led;
        int         rem;
        bit         loa, done;
    } vec_t;

    vec_t vecs[14];

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        int k;
        int n;

        vecs[0]  = '{1, 0, 0, 4'b1111, 4, 0, 0};
        vecs[1]  = '{0, 0, 0, 4'b1111, 4, 0, 0};
        vecs[2]  = '{0, 0, 0, 4'b1111, 4, 0, 0};
        vecs[3]  = '{0, 0, 0, 4'b0111, 3, 0, 0};
        vecs[4]  = '{0, 0, 0, 4'b0111, 3, 0, 0};
        vecs[5]  = '{0, 0, 0, 4'b0111, 3, 0, 0};
        vecs[6]  = '{0, 0, 0, 4'b0011, 2, 0, 0};
        vecs[7]  = '{0, 0, 0, 4'b0011, 2, 0, 0};
        vecs[8]  = '{0, 0, 0, 4'b0011, 2, 0, 0};
        vecs[9]  = '{0, 0, 0, 4'b0001, 1, 0, 0};
        vecs[10] = '{0, 0, 0, 4'b0001, 1, 0, 0};
        vecs[11] = '{0, 0, 0, 4'b0001, 1, 0, 0};
        vecs[12] = '{0, 0, 0, 4'b0000, 0, 1, 1};
        vecs[13] = '{0, 0, 0, 4'b0000, 0, 1, 0};

        // Reset state
        #2 resetn = 1'b0;
        #1 check_zero("reset");
        repeat (2) @(posedge clock);
        @(negedge clock) resetn = 1'b1;
        model_reset();

        // Idle for 20 cycles: nothing lights, done never pulses
        repeat (20) cycle(0, 0, 0);

        // Full countdown from the table
        for (int i = 0; i < 14; i++) begin
            cycle(vecs[i].s, vecs[i].p, vecs[i].a);
            check($sformatf("vec%0d_led", i),  led,       vecs[i].led);
            check($sformatf("vec%0d_rem", i),  remaining, vecs[i].rem);
            check($sformatf("vec%0d_loa", i),  loa,       vecs[i].loa);
            check($sformatf("vec%0d_done", i), done,      vecs[i].done);
        end

`ifdef LED_COUNTDOWN_BLINK_EN
        // Blink: bar goes fully on, stays 3 cycles, then fully off
        k = 0;
        while (led !== 4'hF && k < 10) begin
            cycle(0, 0, 0);
            k++;
        end
        check("blink_on_reached", led, 4'hF);
        cycle(0, 0, 0); check("blink_on_hold1", led, 4'hF);
        cycle(0, 0, 0); check("blink_on_hold2", led, 4'hF);
        cycle(0, 0, 0); check("blink_off", led, 4'h0);
        check("blink_loa", loa, 1);
`else
        repeat (4) cycle(0, 0, 0);
        check("done_dark", led, 4'h0);
`endif

        // Restart from DONE: loa drops and bar refills on the same edge
        cycle(1, 0, 0);
        check("restart_loa", loa, 0);
        check("restart_led", led, 4'hF);
        check("restart_rem", remaining, 4);
        // start while running is ignored
        cycle(1, 0, 0);
        cycle(0, 0, 0);
        cycle(1, 0, 0);
        check("run_start_ignored", led, 4'b0111);

        // Abort at remaining==2 together with start: abort wins, no restart
        k = 0;
        while (m_rem() != 2 && k < 30) begin
            cycle(0, 0, 0);
            k++;
        end
        check("abort_setup_rem", remaining, 2);
        cycle(1, 0, 1);
        check_zero("abort");
        cycle(0, 0, 0);
        check("abort_no_restart", remaining, 0);
        cycle(1, 0, 0);
        check("fresh_run_led", led, 4'hF);

        // Pause 5 cycles mid-run: finish lands 5 cycles late
        n = 0;
        repeat (4) begin cycle(0, 0, 0); n++; end
        begin
            logic [3:0] frozen;
            frozen = led;
            repeat (5) begin
                cycle(0, 1, 0);
                n++;
                check("pause_frozen", led, frozen);
            end
        end
        while (done !== 1'b1 && n < 40) begin
            cycle(0, 0, 0);
            n++;
        end
        check("pause_finish_cycles", n, N * T + 5);

        // Pause does not block start from DONE
        cycle(1, 1, 0);
        check("start_while_paused", led, 4'hF);
        cycle(0, 0, 1);

        // Randomised traffic against the model
        for (int i = 0; i < 1500; i++) begin
            cycle($urandom_range(0, 9) == 0,
                  $urandom_range(0, 4) == 0,
                  $urandom_range(0, 39) == 0);
        end

        // Asynchronous reset in the middle of a run
        cycle(0, 0, 1);
        cycle(1, 0, 0);
        repeat (4) cycle(0, 0, 0);
        #2 resetn = 1'b0;
        #1 check_zero("async_reset_run");
        model_reset();
        @(negedge clock) resetn = 1'b1;

        // Asynchronous reset while in DONE (mid-blink when blinking is built in)
        cycle(1, 0, 0);
        repeat (N * T + 4) cycle(0, 0, 0);
        check("pre_reset_loa", loa, 1);
        #2 resetn = 1'b0;
        #1 check_zero("async_reset_done");
        model_reset();
        @(negedge clock) resetn = 1'b1;
        repeat (3) cycle(0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
